// File: rtl/design1_pkg.sv
// Shared constants for the design1 task accelerator: register map, task IDs, word counts, FSM states.
// DESIGN1_TASK10_EN enables the task 10 (sum-of-4, x9) datapath.
package design1_pkg;

  localparam int ADDR_W    = 17;
  localparam int IN_WORDS  = 512;
  localparam int OUT_WORDS = 512;
  localparam int WORD_AW   = 9;

  localparam logic [ADDR_W-1:0] OFF_IN_BASE       = 17'h00000;
  localparam logic [ADDR_W-1:0] OFF_OUT_BASE      = 17'h00800;
  localparam logic [ADDR_W-1:0] OFF_PL_READY      = 17'h10000;
  localparam logic [ADDR_W-1:0] OFF_ENABLED_TASKS = 17'h10004;
  localparam logic [ADDR_W-1:0] OFF_CURRENT_TASK  = 17'h10008;
  localparam logic [ADDR_W-1:0] OFF_TV_IN_READY   = 17'h1000C;
  localparam logic [ADDR_W-1:0] OFF_TV_OUT_READY  = 17'h10010;

  localparam logic [7:0] TASK_TICK  = 8'd1;
  localparam logic [7:0] TASK_BSWAP = 8'd3;
  localparam logic [7:0] TASK_SUM9  = 8'd10;

  localparam logic [WORD_AW-1:0] WORDS_TICK  = 9'd250;
  localparam logic [WORD_AW-1:0] WORDS_BSWAP = 9'd128;
  localparam logic [WORD_AW-1:0] WORDS_SUM9  = 9'd128;

`ifdef DESIGN1_TASK10_EN
  localparam logic [31:0] ENABLED_TASKS = 32'h0000_040A;
`else
  localparam logic [31:0] ENABLED_TASKS = 32'h0000_000A;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  // Zero words marks a task as unimplemented.
  function automatic logic [WORD_AW-1:0] task_words(input logic [7:0] id);
    case (id)
      TASK_TICK:  return WORDS_TICK;
      TASK_BSWAP: return WORDS_BSWAP;
`ifdef DESIGN1_TASK10_EN
      TASK_SUM9:  return WORDS_SUM9;
`endif
      default:    return '0;
    endcase
  endfunction

endpackage

// File: rtl/design1_task_engine.sv
// Task engine: walks the input buffer and writes results through the output-buffer write port.
// DESIGN1_TASK10_EN builds the task 10 accumulator and x9 datapath.
//   state   | meaning
//   ST_IDLE | waiting for start
//   ST_RUN  | issuing input reads / writing output words
//   ST_DONE | one-cycle completion pulse
module design1_task_engine
  import design1_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [7:0]         i_task,
  output logic [WORD_AW-1:0] o_in_addr,
  input  logic [31:0]        i_in_rdata,
  output logic               o_out_we,
  output logic [WORD_AW-1:0] o_out_addr,
  output logic [31:0]        o_out_wdata,
  output logic               o_busy,
  output logic               o_done
);

  state_t             r_state;
  logic [7:0]         r_task;
  logic [WORD_AW-1:0] r_words;
  logic [WORD_AW-1:0] r_idx;
  logic [WORD_AW-1:0] r_vidx;
  logic               r_vld;
  logic               r_out_we;
  logic [WORD_AW-1:0] r_out_addr;
  logic [31:0]        r_out_wdata;
  logic               r_busy;
  logic               r_done;
  logic               w_issue;
  logic               w_pend;
  logic [31:0]        w_bswap;

  assign w_issue = (r_idx != r_words);
  assign w_bswap = {i_in_rdata[7:0], i_in_rdata[15:8], i_in_rdata[23:16], i_in_rdata[31:24]};

`ifdef DESIGN1_TASK10_EN
  logic [63:0]        r_acc;
  logic [31:0]        r_hi;
  logic [WORD_AW-1:0] r_hi_addr;
  logic               r_hi_pend;
  logic [63:0]        w_sum;
  logic [63:0]        w_r9;

  assign w_sum  = r_acc + {32'b0, i_in_rdata};
  assign w_r9   = (w_sum << 3) + w_sum;
  assign w_pend = r_hi_pend;
`else
  assign w_pend = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_task      <= '0;
      r_words     <= '0;
      r_idx       <= '0;
      r_vidx      <= '0;
      r_vld       <= 1'b0;
      r_out_we    <= 1'b0;
      r_out_addr  <= '0;
      r_out_wdata <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef DESIGN1_TASK10_EN
      r_acc       <= '0;
      r_hi        <= '0;
      r_hi_addr   <= '0;
      r_hi_pend   <= 1'b0;
`endif
    end else begin
      r_vld    <= 1'b0;
      r_out_we <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_task  <= i_task;
            r_words <= task_words(i_task);
            r_idx   <= '0;
            r_busy  <= 1'b1;
`ifdef DESIGN1_TASK10_EN
            r_acc     <= '0;
            r_hi_pend <= 1'b0;
`endif
            if (task_words(i_task) != '0) begin
              r_state <= ST_RUN;
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          // Read data for r_vidx arrives one cycle after its address was issued.
          if (w_issue) begin
            r_idx  <= r_idx + WORD_AW'(1);
            r_vld  <= 1'b1;
            r_vidx <= r_idx;
            if (r_task == TASK_TICK) begin
              r_out_we    <= 1'b1;
              r_out_addr  <= r_idx;
              r_out_wdata <= {31'b0, r_idx == '0};
            end
          end
          if (r_vld && r_task == TASK_BSWAP) begin
            r_out_we    <= 1'b1;
            r_out_addr  <= r_vidx;
            r_out_wdata <= w_bswap;
          end
`ifdef DESIGN1_TASK10_EN
          if (r_hi_pend) begin
            r_out_we    <= 1'b1;
            r_out_addr  <= r_hi_addr;
            r_out_wdata <= r_hi;
            r_hi_pend   <= 1'b0;
          end
          // The upper half is written the following cycle, which never carries a low-half write.
          if (r_vld && r_task == TASK_SUM9) begin
            if (r_vidx[1:0] == 2'd3) begin
              r_out_we    <= 1'b1;
              r_out_addr  <= {1'b0, r_vidx[WORD_AW-1:2], 1'b0};
              r_out_wdata <= w_r9[31:0];
              r_hi        <= w_r9[63:32];
              r_hi_addr   <= {1'b0, r_vidx[WORD_AW-1:2], 1'b1};
              r_hi_pend   <= 1'b1;
              r_acc       <= '0;
            end else begin
              r_acc <= w_sum;
            end
          end
`endif
          if (!w_issue && !r_vld && !w_pend) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_in_addr   = r_idx;
  assign o_out_we    = r_out_we;
  assign o_out_addr  = r_out_addr;
  assign o_out_wdata = r_out_wdata;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: rtl/design1_wrapper.sv
// Top of the design1 accelerator: bus decode, control registers and the input/output buffers.
// DESIGN1_TASK10_EN (see design1_pkg) selects whether task 10 is built.
module design1_wrapper
  import design1_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_wr,
  input  logic [31:0]       bus_wdata,
  input  logic              bus_rd,
  output logic [31:0]       bus_rdata,
  output logic              bus_rvalid,
  output logic              busy
);

  logic [31:0]        r_in_mem  [IN_WORDS];
  logic [31:0]        r_out_mem [OUT_WORDS];
  logic [31:0]        r_eng_rdata;
  logic [7:0]         r_cur_task;
  logic               r_tv_in;
  logic               r_tv_out;

  logic [WORD_AW-1:0] w_word;
  logic               w_in_sel;
  logic               w_out_sel;
  logic               w_wr_task;
  logic               w_start;
  logic               w_busy;
  logic               w_done;
  logic [WORD_AW-1:0] w_eng_in_addr;
  logic               w_eng_out_we;
  logic [WORD_AW-1:0] w_eng_out_addr;
  logic [31:0]        w_eng_out_wdata;
  logic [31:0]        w_reg_rdata;
  logic               w_unused_addr;

  assign w_unused_addr = ^bus_addr[1:0];
  assign w_word    = bus_addr[WORD_AW+1:2];
  assign w_in_sel  = (bus_addr[ADDR_W-1:11] == OFF_IN_BASE[ADDR_W-1:11]);
  assign w_out_sel = (bus_addr[ADDR_W-1:11] == OFF_OUT_BASE[ADDR_W-1:11]);
  assign w_wr_task = bus_wr && (bus_addr[ADDR_W-1:2] == OFF_CURRENT_TASK[ADDR_W-1:2]);
  assign w_start   = bus_wr && !w_busy && bus_wdata[0] &&
                     (bus_addr[ADDR_W-1:2] == OFF_TV_IN_READY[ADDR_W-1:2]);

  design1_task_engine u_engine (
    .clk         (clk),
    .rst         (rst),
    .i_start     (w_start),
    .i_task      (r_cur_task),
    .o_in_addr   (w_eng_in_addr),
    .i_in_rdata  (r_eng_rdata),
    .o_out_we    (w_eng_out_we),
    .o_out_addr  (w_eng_out_addr),
    .o_out_wdata (w_eng_out_wdata),
    .o_busy      (w_busy),
    .o_done      (w_done)
  );

  // Host port writes the input buffer; the engine reads it on the second port.
  always_ff @(posedge clk) begin
    if (bus_wr && w_in_sel && !w_busy) r_in_mem[w_word] <= bus_wdata;
    r_eng_rdata <= r_in_mem[w_eng_in_addr];
  end

  always_ff @(posedge clk) begin
    if (w_eng_out_we) r_out_mem[w_eng_out_addr] <= w_eng_out_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur_task <= '0;
      r_tv_in    <= 1'b0;
      r_tv_out   <= 1'b0;
    end else begin
      r_tv_in <= w_start;
      if (w_wr_task && !w_busy) r_cur_task <= bus_wdata[7:0];
      if (w_start)     r_tv_out <= 1'b0;
      else if (w_done) r_tv_out <= 1'b1;
    end
  end

  always_comb begin
    w_reg_rdata = '0;
    case (bus_addr[ADDR_W-1:2])
      OFF_PL_READY[ADDR_W-1:2]:      w_reg_rdata = 32'd1;
      OFF_ENABLED_TASKS[ADDR_W-1:2]: w_reg_rdata = ENABLED_TASKS;
      OFF_CURRENT_TASK[ADDR_W-1:2]:  w_reg_rdata = {24'b0, r_cur_task};
      OFF_TV_IN_READY[ADDR_W-1:2]:   w_reg_rdata = {31'b0, r_tv_in};
      OFF_TV_OUT_READY[ADDR_W-1:2]:  w_reg_rdata = {31'b0, r_tv_out};
      default:                       w_reg_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_rdata  <= '0;
      bus_rvalid <= 1'b0;
    end else begin
      bus_rvalid <= bus_rd;
      if (bus_rd) begin
        if (w_in_sel)       bus_rdata <= r_in_mem[w_word];
        else if (w_out_sel) bus_rdata <= r_out_mem[w_word];
        else                bus_rdata <= w_reg_rdata;
      end
    end
  end

  assign busy = w_busy;

endmodule

// File: tb/tb_design1_wrapper.sv
// Directed self-checking bench for design1_wrapper; expectations follow DESIGN1_TASK10_EN.
module tb_design1_wrapper;
  import design1_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_wr;
  logic [31:0]       bus_wdata;
  logic              bus_rd;
  logic [31:0]       bus_rdata;
  logic              bus_rvalid;
  logic              busy;

  int checks = 0;
  int errors = 0;

  design1_wrapper dut (
    .clk        (clk),
    .rst        (rst),
    .bus_addr   (bus_addr),
    .bus_wr     (bus_wr),
    .bus_wdata  (bus_wdata),
    .bus_rd     (bus_rd),
    .bus_rdata  (bus_rdata),
    .bus_rvalid (bus_rvalid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    bus_addr  = a;
    bus_wdata = d;
    bus_wr    = 1'b1;
    @(posedge clk); #1;
    bus_wr    = 1'b0;
  endtask

  task automatic bus_read(input logic [ADDR_W-1:0] a, output logic [31:0] d, output logic v);
    bus_addr = a;
    bus_rd   = 1'b1;
    @(posedge clk); #1;
    d        = bus_rdata;
    v        = bus_rvalid;
    bus_rd   = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [ADDR_W-1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic        v;
    bus_read(a, d, v);
    check(tag, d, exp);
  endtask

  task automatic wait_done(input string tag, input int limit, output int polls);
    logic [31:0] d;
    logic        v;
    polls = 0;
    do begin
      bus_read(OFF_TV_OUT_READY, d, v);
      polls++;
    end while (d[0] !== 1'b1 && polls < limit);
    check(tag, d, 32'd1);
  endtask

  function automatic logic [ADDR_W-1:0] in_a(input int i);
    return OFF_IN_BASE + ADDR_W'(i * 4);
  endfunction

  function automatic logic [ADDR_W-1:0] out_a(input int i);
    return OFF_OUT_BASE + ADDR_W'(i * 4);
  endfunction

  initial begin
    logic [31:0] d;
    logic        v;
    int          polls;
    int          pop;

    rst = 1'b1; bus_addr = '0; bus_wr = 1'b0; bus_wdata = '0; bus_rd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus_addr = OFF_PL_READY; bus_rd = 1'b1;
    @(posedge clk); #1;
    bus_rd = 1'b0;
    check("rst_rdata", bus_rdata, 32'd0);
    check("rst_rvalid", {31'b0, bus_rvalid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;

    bus_read(OFF_PL_READY, d, v);
    check("pl_ready", d, 32'd1);
    check("rvalid", {31'b0, v}, 32'd1);
`ifdef DESIGN1_TASK10_EN
    read_check("enabled_tasks", OFF_ENABLED_TASKS, 32'h40A);
`else
    read_check("enabled_tasks", OFF_ENABLED_TASKS, 32'h00A);
`endif
    read_check("cur_task_rst", OFF_CURRENT_TASK, 32'd0);
    read_check("tv_in_rst", OFF_TV_IN_READY, 32'd0);
    read_check("tv_out_rst", OFF_TV_OUT_READY, 32'd0);
    read_check("unmapped_reg", 17'h10014, 32'd0);
    read_check("unmapped_mid", 17'h01000, 32'd0);

    // Task 3: byte reverse
    for (int i = 0; i < 128; i++) bus_write(in_a(i), 32'h00010203 + 32'(i));
    bus_write(OFF_CURRENT_TASK, 32'd3);
    read_check("cur_task_wr", OFF_CURRENT_TASK, 32'd3);
    bus_write(OFF_TV_IN_READY, 32'd1);
    check("t3_busy", {31'b0, busy}, 32'd1);
    read_check("tv_in_set", OFF_TV_IN_READY, 32'd1);
    read_check("tv_in_clr", OFF_TV_IN_READY, 32'd0);
    bus_write(OFF_CURRENT_TASK, 32'd5);
    bus_write(in_a(5), 32'hDEAD_BEEF);
    read_check("cur_task_busy", OFF_CURRENT_TASK, 32'd3);
    wait_done("t3_done", 400, polls);
    check("t3_idle", {31'b0, busy}, 32'd0);
    read_check("t3_out0", out_a(0), 32'h03020100);
    read_check("t3_out64", out_a(64), 32'h43020100);
    read_check("t3_out127", out_a(127), 32'h82020100);
    read_check("in_busy_drop", in_a(5), 32'h00010208);

    // Task 10: sum of four, times nine
    for (int i = 0; i < 4; i++) bus_write(in_a(i), 32'(i + 1));
    for (int i = 4; i < 8; i++) bus_write(in_a(i), 32'hFFFF_FFFF);
    bus_write(OFF_CURRENT_TASK, 32'd10);
    bus_write(OFF_TV_IN_READY, 32'd1);
    wait_done("t10_done", 400, polls);
`ifdef DESIGN1_TASK10_EN
    read_check("t10_out0", out_a(0), 32'd90);
    read_check("t10_out1", out_a(1), 32'd0);
    read_check("t10_out2", out_a(2), 32'hFFFF_FFDC);
    read_check("t10_out3", out_a(3), 32'h0000_0023);
    read_check("t10_out62", out_a(62), 32'h0024_5A12);
    read_check("t10_out63", out_a(63), 32'd0);
`else
    read_check("t10_out0", out_a(0), 32'h03020100);
    read_check("t10_out1", out_a(1), 32'h04020100);
    read_check("t10_out2", out_a(2), 32'h05020100);
    read_check("t10_out3", out_a(3), 32'h06020100);
    read_check("t10_out62", out_a(62), 32'h41020100);
`endif

    // Task 1: single tick
    bus_write(OFF_CURRENT_TASK, 32'd1);
    bus_write(OFF_TV_IN_READY, 32'd1);
    wait_done("t1_done", 400, polls);
    pop = 0;
    for (int i = 0; i < 250; i++) begin
      bus_read(out_a(i), d, v);
      pop += $countones(d);
    end
    check("t1_popcount", 32'(pop), 32'd1);
    read_check("t1_out0", out_a(0), 32'd1);
    read_check("t1_out127", out_a(127), 32'd0);

    // Task 7: unimplemented
    bus_write(OFF_CURRENT_TASK, 32'd7);
    bus_write(OFF_TV_IN_READY, 32'd1);
    bus_read(OFF_TV_OUT_READY, d, v);
    check("t7_cleared", d, 32'd0);
    wait_done("t7_done_3cyc", 2, polls);
    read_check("t7_out0", out_a(0), 32'd1);
    read_check("t7_out1", out_a(1), 32'd0);

    // Reset in the middle of task 3
    for (int i = 0; i < 8; i++) bus_write(in_a(i), 32'h00010203 + 32'(i));
    bus_write(OFF_CURRENT_TASK, 32'd3);
    bus_write(OFF_TV_IN_READY, 32'd1);
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    read_check("mid_rst_tv_out", OFF_TV_OUT_READY, 32'd0);
    read_check("mid_rst_tv_in", OFF_TV_IN_READY, 32'd0);
    read_check("mid_rst_cur_task", OFF_CURRENT_TASK, 32'd0);
    read_check("mid_rst_partial", out_a(0), 32'h03020100);
    bus_write(OFF_CURRENT_TASK, 32'd3);
    bus_write(OFF_TV_IN_READY, 32'd1);
    wait_done("rerun_done", 400, polls);
    read_check("rerun_out0", out_a(0), 32'h03020100);
    read_check("rerun_out7", out_a(7), 32'h0A020100);
    read_check("rerun_out127", out_a(127), 32'h82020100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
